dsram_like_adapter: RTL and testbench
=====================================

Name: dsram_like_adapter

Overview:
- Data-side memory-stage adapter between the MIPS core's M-stage data port and the SRAM-like bus.
- The bus feeds the AXI bridge downstream.
- Converts the core's single-cycle request signals into a two-phase req/addr_ok/data_ok handshake.
- Generates dataStall and returns held readdataM until the whole pipeline releases.

Parameters:
- TIMEOUT_CYCLES, 1023, watchdog limit in cycles (used only with the optional feature).
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- mem_enM  in  1  M-stage memory access valid
- memreadM  in  1  1 = load, 0 = store
- selectM  in  4  byte-lane enables, already lane-aligned by core
- aluoutM  in  32  byte address
- writedataM  in  32  store data, lane-aligned
- longest_stall  in  1  global pipeline stall from core
- readdataM  out  32  load data returned to core
- dataStall  out  1  stall request to core
- data_req  out  1  SRAM-like request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  request address
- data_wdata  out  32  write data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  32  read data
- timeout_err  out  1  sticky watchdog flag (optional feature only)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- On reset: state = IDLE; readdataM = 0; dataStall = 0; data_req = 0; all latched attributes = 0; timeout_err = 0.
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, DONE.
- IDLE:
  - data_req = mem_enM, combinational.
  - Attributes come directly from the inputs: data_addr = aluoutM, data_wr = ~memreadM, data_wdata = writedataM.
  - data_size decode of selectM: 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; 1111 -> 2; any other value -> 2.
  - On mem_enM, latch the attributes every cycle.
  - mem_enM & addr_ok & data_ok -> DONE.
  - mem_enM & addr_ok -> WAIT_DATA.
  - mem_enM & ~addr_ok -> WAIT_ADDR.
- WAIT_ADDR:
  - data_req = 1, with the latched attributes held stable.
  - The request holds even if mem_enM drops; an issued request is never withdrawn.
  - addr_ok & data_ok -> DONE.
  - addr_ok -> WAIT_DATA.
- WAIT_DATA:
  - data_req = 0.
  - data_ok -> DONE.
- DONE:
  - data_req = 0.
  - Leave for IDLE on ~longest_stall; no reissue while the same instruction remains in M.
- Read data capture:
  - When data_ok arrives on a load, register readdataM <= data_rdata.
  - readdataM holds until the next load's data_ok.
  - Stores do not modify readdataM.
- dataStall = (IDLE & mem_enM) | WAIT_ADDR | WAIT_DATA.
  - It is 0 in DONE, so the minimum stall is 1 cycle (addr_ok and data_ok in the request cycle).
- Protocol rules:
  - data_ok is accepted in the same cycle as addr_ok or any later cycle.
  - data_ok without an outstanding request is ignored.
  - Only one transaction is outstanding at a time.
- Exceptions and flush:
  - The core gates mem_enM for faulting instructions.
  - The adapter completes any accepted transaction regardless of flushM.
- Reset mid-transaction: return to IDLE immediately and drop data_req; the bus side must be reset by the same rst.

Optional Feature:
- Macro: DSRAM_TIMEOUT_EN.
- With the macro defined:
  - The counter clears on entering WAIT_ADDR or WAIT_DATA from IDLE and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES: set timeout_err (sticky until reset), force the FSM to DONE, and set readdataM = 32'hDEAD_BEEF.
- Without the macro: no counter exists and timeout_err is tied to 0.

Decomposition:
- Shared package mips_bus_defs:
  - state encoding constants S_IDLE = 2'd0, S_WADDR = 2'd1, S_WDATA = 2'd2, S_DONE = 2'd3;
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - timeout fill value.
- One sub-module, sel2size: combinational selectM -> data_size decoder, reusable by the instruction-side adapter.

Test Plan:
- Load, addr_ok and data_ok both in the request cycle, rdata = 32'h1234_5678:
  - dataStall high for exactly 1 cycle;
  - readdataM = 32'h1234_5678 the next cycle;
  - data_req pulses once.
- Store, selectM = 4'b1100, addr = 32'hBFC0_0002, addr_ok delayed 3 cycles, data_ok 2 cycles after that:
  - data_req held 4 cycles with size = 1, wr = 1, addr stable;
  - dataStall high 6 cycles.
- Load completes while longest_stall stays high 5 more cycles (instruction-side stall):
  - FSM holds DONE with no second data_req;
  - readdataM stable;
  - returns to IDLE the cycle after longest_stall falls.
- Back-to-back loads to 32'h0 and 32'h4:
  - each gets exactly one request;
  - readdataM updates in order;
  - no request is lost between DONE -> IDLE -> IDLE.
- rst asserted in WAIT_DATA:
  - data_req, dataStall and readdataM are 0 asynchronously;
  - a late data_ok after reset release is ignored.
- DSRAM_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and addr_ok never asserted:
  - after 8 cycles timeout_err = 1, dataStall = 0, readdataM = 32'hDEAD_BEEF.

Source files
------------

// File: rtl/mips_bus_defs.sv
// Shared definitions for the MIPS core's SRAM-like bus adapters: FSM encoding,
// access-size codes and the watchdog fill value.
package mips_bus_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WADDR = 2'd1,
        S_WDATA = 2'd2,
        S_DONE  = 2'd3
    } bus_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/sel2size.sv
// Byte-lane enable to SRAM-like access size decoder; shared with the
// instruction-side adapter.
module sel2size
    import mips_bus_defs::*;
(
    input  logic [3:0] sel_i,
    output logic [1:0] size_o
);

    always_comb begin
        size_o = SZ_WORD;
        case (sel_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SZ_BYTE;
            4'b0011, 4'b1100:                   size_o = SZ_HALF;
            // Full word and any irregular lane pattern go out as a word access
            default:                            size_o = SZ_WORD;
        endcase
    end

endmodule

// File: rtl/dsram_like_adapter.sv
// Data-side M-stage adapter: core single-cycle requests to SRAM-like req/addr_ok/data_ok.
// Optional watchdog (counter, timeout_err, 32'hDEAD_BEEF fill) enabled by DSRAM_TIMEOUT_EN.
module dsram_like_adapter
    import mips_bus_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enM,
    input  logic        memreadM,
    input  logic [3:0]  selectM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        longest_stall,
    output logic [31:0] readdataM,
    output logic        dataStall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        timeout_err
);

    bus_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [1:0]  sel_size;
    logic        req, stall, load_done, timeout_hit;
    logic        in_idle;

    sel2size u_sel2size (
        .sel_i  (selectM),
        .size_o (sel_size)
    );

    assign in_idle = (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        stall     = 1'b0;
        load_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                req   = mem_enM;
                stall = mem_enM;
                if (mem_enM) begin
                    if (data_addr_ok && data_data_ok) begin
                        state_d   = S_DONE;
                        load_done = memreadM;
                    end else if (data_addr_ok) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_WADDR;
                    end
                end
            end
            S_WADDR: begin
                // Once issued the request stays up regardless of mem_enM
                req   = 1'b1;
                stall = 1'b1;
                if (data_addr_ok && data_data_ok) begin
                    state_d   = S_DONE;
                    load_done = ~wr_q;
                end else if (data_addr_ok) begin
                    state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                stall = 1'b1;
                if (data_data_ok) begin
                    state_d   = S_DONE;
                    load_done = ~wr_q;
                end
            end
            S_DONE: begin
                // Hold until the pipeline moves so the same instruction is not reissued
                if (!longest_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_idle && mem_enM) begin
                addr_q  <= aluoutM;
                wdata_q <= writedataM;
                wr_q    <= ~memreadM;
                size_q  <= sel_size;
            end
            if (timeout_hit) begin
                rdata_q <= TIMEOUT_FILL;
            end else if (load_done) begin
                rdata_q <= data_rdata;
            end
        end
    end

`ifdef DSRAM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
    logic             waiting;

    assign waiting     = (state_q == S_WADDR) || (state_q == S_WDATA);
    assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (in_idle) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^(TIMEOUT_CYCLES ^ CNT_W);
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Bus request and stall are forced low while reset is held
    assign data_req   = req & rst;
    assign dataStall  = stall & rst;
    assign data_wr    = in_idle ? ~memreadM  : wr_q;
    assign data_size  = in_idle ? sel_size   : size_q;
    assign data_addr  = in_idle ? aluoutM    : addr_q;
    assign data_wdata = in_idle ? writedataM : wdata_q;
    assign readdataM  = rdata_q;

endmodule

// File: tb/tb_dsram_like_adapter.sv
// Self-checking bench for dsram_like_adapter: a cycle-level core/bus model with a
// scoreboard of expected load data. Define DSRAM_TIMEOUT_EN to also cover the watchdog.
module tb_dsram_like_adapter;

`ifdef DSRAM_TIMEOUT_EN
    localparam int unsigned TB_TO = 8;
    localparam int unsigned TB_CW = 4;
`else
    localparam int unsigned TB_TO = 1023;
    localparam int unsigned TB_CW = 10;
`endif

    logic        clk, rst;
    logic        mem_enM, memreadM, longest_stall;
    logic [3:0]  selectM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        dataStall, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_rd = 32'h0;

    dsram_like_adapter #(
        .TIMEOUT_CYCLES (TB_TO),
        .CNT_W          (TB_CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_enM       (mem_enM),
        .memreadM      (memreadM),
        .selectM       (selectM),
        .aluoutM       (aluoutM),
        .writedataM    (writedataM),
        .longest_stall (longest_stall),
        .readdataM     (readdataM),
        .dataStall     (dataStall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_size(input logic [3:0] s);
        case (s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            4'b0011, 4'b1100:                   return 2'd1;
            default:                            return 2'd2;
        endcase
    endfunction

    // Drives one access as the core plus an SRAM-like slave; measures, does not judge.
    // addr_ok after a_dly request cycles, data_ok d_dly cycles after addr_ok,
    // then longest_stall held for 'hold' extra cycles in DONE.
    task automatic run_access(input bit ld, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int a_dly, input int d_dly, input int hold,
                              output int req_cyc, output int stall_cyc, output int attr_bad,
                              output int rd_moves, output bit first_req, output bit done);
        int acnt, dcnt;
        bit accepted;
        logic [31:0] rd0;
        req_cyc = 0; stall_cyc = 0; attr_bad = 0; rd_moves = 0;
        first_req = 1'b0; done = 1'b0;
        acnt = 0; dcnt = 0; accepted = 1'b0; rd0 = '0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            mem_enM = 1'b1; memreadM = ld; selectM = sel; aluoutM = addr;
            writedataM = wdata; longest_stall = 1'b1;
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
            if (!accepted) begin
                if (acnt == a_dly) begin
                    data_addr_ok = 1'b1;
                    data_data_ok = (d_dly == 0);
                end
            end else if (dcnt == d_dly) begin
                data_data_ok = 1'b1;
            end
            data_rdata = data_data_ok ? rdata : (32'hBAD0_0000 ^ 32'(cyc));
            #1;
            if (cyc == 0) first_req = data_req;
            if (data_req) begin
                req_cyc++;
                if (data_addr !== addr || data_wr !== ~ld || data_size !== exp_size(sel) ||
                    data_wdata !== wdata) attr_bad++;
            end
            if (dataStall) stall_cyc++;
            if (!accepted) begin
                if (data_addr_ok) begin accepted = 1'b1; dcnt = 1; end
                else acnt++;
            end else begin
                dcnt++;
            end
            if (data_data_ok) done = 1'b1;
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hBAD1_0000 ^ 32'(h);
            longest_stall = (h < hold);
            #1;
            if (data_req) req_cyc++;
            if (dataStall) stall_cyc++;
            if (h == 0) rd0 = readdataM;
            else if (readdataM !== rd0) rd_moves++;
        end
    endtask

    task automatic check_load(input string name);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, readdataM=%h", name, readdataM);
        end else begin
            e = exp_q.pop_front();
            model_rd = e;
            if (readdataM !== e) begin
                failures++;
                $display("FAIL %s: readdataM=%h expected=%h", name, readdataM, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_enM = 1'b1; memreadM = 1'b1; selectM = 4'hF; aluoutM = '0;
        writedataM = '0; longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = '0;
        #12;
        checks++; if (data_req !== 1'b0) begin failures++;
            $display("FAIL reset_req: got=%b expected=0", data_req); end
        checks++; if (dataStall !== 1'b0) begin failures++;
            $display("FAIL reset_stall: got=%b expected=0", dataStall); end
        checks++; if (readdataM !== 32'h0) begin failures++;
            $display("FAIL reset_rdata: got=%h expected=0", readdataM); end
        checks++; if (timeout_err !== 1'b0) begin failures++;
            $display("FAIL reset_err: got=%b expected=0", timeout_err); end
        @(negedge clk);
        rst = 1'b1; mem_enM = 1'b0;
    endtask

    task automatic test_single_cycle();
        int rq, st, ab, rm; bit fr, dn;
        exp_q.push_back(32'h1234_5678);
        run_access(1'b1, 4'hF, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0, 0,
                   rq, st, ab, rm, fr, dn);
        checks++; if (!dn) begin failures++; $display("FAIL single_done: got=0 expected=1"); end
        checks++; if (rq != 1) begin failures++;
            $display("FAIL single_req: got=%0d expected=1", rq); end
        checks++; if (st != 1) begin failures++;
            $display("FAIL single_stall: got=%0d expected=1", st); end
        checks++; if (ab != 0) begin failures++;
            $display("FAIL single_attr: bad=%0d expected=0", ab); end
        check_load("single_rdata");
    endtask

    task automatic test_store_delayed();
        int rq, st, ab, rm; bit fr, dn;
        run_access(1'b0, 4'b1100, 32'hBFC0_0002, 32'hA5A5_0000, 32'h0, 3, 2, 0,
                   rq, st, ab, rm, fr, dn);
        checks++; if (!dn) begin failures++; $display("FAIL store_done: got=0 expected=1"); end
        checks++; if (rq != 4) begin failures++;
            $display("FAIL store_req: got=%0d expected=4", rq); end
        checks++; if (st != 6) begin failures++;
            $display("FAIL store_stall: got=%0d expected=6", st); end
        checks++; if (ab != 0) begin failures++;
            $display("FAIL store_attr: bad=%0d expected=0", ab); end
        checks++; if (readdataM !== model_rd) begin failures++;
            $display("FAIL store_rdata: got=%h expected=%h", readdataM, model_rd); end
    endtask

    task automatic test_hold();
        int rq, st, ab, rm; bit fr, dn;
        exp_q.push_back(32'hCAFE_0001);
        run_access(1'b1, 4'hF, 32'h0000_0200, 32'h0, 32'hCAFE_0001, 0, 1, 5,
                   rq, st, ab, rm, fr, dn);
        checks++; if (rq != 1) begin failures++;
            $display("FAIL hold_req: got=%0d expected=1", rq); end
        checks++; if (st != 2) begin failures++;
            $display("FAIL hold_stall: got=%0d expected=2", st); end
        checks++; if (rm != 0) begin failures++;
            $display("FAIL hold_rdata_stable: moves=%0d expected=0", rm); end
        check_load("hold_rdata");
        // The next instruction must be requested in the very first cycle after release
        exp_q.push_back(32'hCAFE_0002);
        run_access(1'b1, 4'hF, 32'h0000_0204, 32'h0, 32'hCAFE_0002, 0, 0, 0,
                   rq, st, ab, rm, fr, dn);
        checks++; if (fr !== 1'b1) begin failures++;
            $display("FAIL hold_release_req: got=%b expected=1", fr); end
        check_load("hold_next_rdata");
    endtask

    task automatic test_sizes();
        logic [3:0] sels [5] = '{4'b0001, 4'b1000, 4'b0011, 4'b0110, 4'b1111};
        int rq, st, ab, rm; bit fr, dn;
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, sels[i], 32'h0000_1000 + 32'(i * 4), 32'h1111_0000 + 32'(i),
                       32'h0, 1, 1, 0, rq, st, ab, rm, fr, dn);
            checks++; if (ab != 0 || rq != 2) begin failures++;
                $display("FAIL size_sel_%b: attr_bad=%0d req=%0d expected 0/2", sels[i], ab, rq);
            end
        end
        checks++; if (readdataM !== model_rd) begin failures++;
            $display("FAIL size_rdata: got=%h expected=%h", readdataM, model_rd); end
    endtask

    task automatic test_back_to_back();
        int rq, st, ab, rm; bit fr, dn;
        exp_q.push_back(32'h0000_AAAA);
        run_access(1'b1, 4'hF, 32'h0, 32'h0, 32'h0000_AAAA, 1, 0, 0, rq, st, ab, rm, fr, dn);
        checks++; if (rq != 2 || !fr) begin failures++;
            $display("FAIL b2b_first_req: got=%0d/%b expected=2/1", rq, fr); end
        check_load("b2b_first_rdata");
        exp_q.push_back(32'h0000_BBBB);
        run_access(1'b1, 4'hF, 32'h4, 32'h0, 32'h0000_BBBB, 0, 2, 0, rq, st, ab, rm, fr, dn);
        checks++; if (rq != 1 || !fr || ab != 0) begin failures++;
            $display("FAIL b2b_second_req: got=%0d/%b/%0d expected=1/1/0", rq, fr, ab); end
        check_load("b2b_second_rdata");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_enM = 1'b1; memreadM = 1'b1; selectM = 4'hF; aluoutM = 32'h0000_0300;
        longest_stall = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        checks++; if (data_req !== 1'b0 || dataStall !== 1'b1) begin failures++;
            $display("FAIL rmid_wait_data: req=%b stall=%b expected 0/1", data_req, dataStall); end
        #1 rst = 1'b0;
        #1;
        checks++; if (data_req !== 1'b0 || dataStall !== 1'b0) begin failures++;
            $display("FAIL rmid_async: req=%b stall=%b expected 0/0", data_req, dataStall); end
        checks++; if (readdataM !== 32'h0) begin failures++;
            $display("FAIL rmid_rdata: got=%h expected=0", readdataM); end
        model_rd = 32'h0;
        @(negedge clk);
        rst = 1'b1; mem_enM = 1'b0;
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'hFEED_F00D;
        #1;
        checks++; if (data_req !== 1'b0 || dataStall !== 1'b0) begin failures++;
            $display("FAIL rmid_late_ok: req=%b stall=%b expected 0/0", data_req, dataStall); end
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        checks++; if (readdataM !== model_rd) begin failures++;
            $display("FAIL rmid_late_rdata: got=%h expected=%h", readdataM, model_rd); end
        longest_stall = 1'b0;
    endtask

`ifdef DSRAM_TIMEOUT_EN
    task automatic test_timeout();
        int st;
        bit released;
        st = 0; released = 1'b0;
        for (int cyc = 0; cyc < 40 && !released; cyc++) begin
            @(negedge clk);
            mem_enM = 1'b1; memreadM = 1'b1; selectM = 4'hF; aluoutM = 32'h0000_0400;
            longest_stall = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0;
            #1;
            if (dataStall) st++;
            else released = 1'b1;
        end
        checks++; if (!released || st != int'(TB_TO) + 1) begin failures++;
            $display("FAIL timeout_stall: released=%b cycles=%0d expected=%0d", released, st,
                     TB_TO + 1); end
        checks++; if (timeout_err !== 1'b1) begin failures++;
            $display("FAIL timeout_err: got=%b expected=1", timeout_err); end
        checks++; if (readdataM !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL timeout_rdata: got=%h expected=deadbeef", readdataM); end
        @(negedge clk);
        longest_stall = 1'b0; mem_enM = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (timeout_err !== 1'b1) begin failures++;
            $display("FAIL timeout_sticky: got=%b expected=1", timeout_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_cycle();
        test_store_delayed();
        test_hold();
        test_sizes();
        test_back_to_back();
        test_reset_mid();
`ifdef DSRAM_TIMEOUT_EN
        test_timeout();
`else
        checks++; if (timeout_err !== 1'b0) begin failures++;
            $display("FAIL err_tied: got=%b expected=0", timeout_err); end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
